// File: rtl/reg_file_param.sv
// Parametrised multi-read-port register file with write-to-read bypass,
// optional hard-wired zero register and a one-entry-per-cycle clear sweep.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       regwrite,
    input  logic [ADDR_W-1:0]          writereg,
    input  logic [DATA_W-1:0]          data,
    input  logic [NUM_RD*ADDR_W-1:0]   readreg,
    output logic [NUM_RD*DATA_W-1:0]   read,
    input  logic                       clear_req,
    output logic                       busy,
    output logic                       clear_done,
    output logic                       wr_reject
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic                clear_done_q, clear_done_d;
    logic                wr_reject_q, wr_reject_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_accept;

    // Writes to the zero register are dropped silently rather than rejected.
    always_comb begin
        wr_accept = regwrite && !busy_q && !clr &&
                    !((ZERO_REG != 0) && (writereg == '0));
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        busy_d       = busy_q;
        clear_done_d = 1'b0;
        wr_reject_d  = 1'b0;
        mem_we       = wr_accept;
        mem_waddr    = writereg;
        mem_wdata    = data;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                mem_we      = 1'b1;
                mem_waddr   = ptr_q;
                mem_wdata   = '0;
                ptr_d       = ptr_q + 1'b1;
                wr_reject_d = regwrite;
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    clear_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (clr) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= SWEEP;
            ptr_q        <= '0;
            busy_q       <= 1'b1;
            clear_done_q <= 1'b0;
            wr_reject_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            wr_reject_q  <= wr_reject_d;
        end
    end

    // The array itself has no reset; it is zeroed only by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;

        assign rd_addr = readreg[k*ADDR_W +: ADDR_W];
        assign rd_data = busy_q                                  ? '0 :
                         ((ZERO_REG != 0) && (rd_addr == '0))    ? '0 :
                         (wr_accept && (writereg == rd_addr))    ? data :
                                                                   mem_q[rd_addr];
        assign read[k*DATA_W +: DATA_W] = rd_data;
    end

    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign wr_reject  = wr_reject_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: a default build (32b, 2 ports, zero reg)
// and a 16b, 4-port build without zero reg, driven with the same controls.
module tb_reg_file_param;

    logic        clk;
    logic        clr;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] data;
    logic        clear_req;

    logic [9:0]  readreg_a;
    logic [63:0] read_a;
    logic        busy_a, clear_done_a, wr_reject_a;

    logic [19:0] readreg_b;
    logic [63:0] read_b;
    logic        busy_b, clear_done_b, wr_reject_b;

    int checks;
    int failures;

    reg_file_param dut_a (
        .clk        (clk),
        .clr        (clr),
        .regwrite   (regwrite),
        .writereg   (writereg),
        .data       (data),
        .readreg    (readreg_a),
        .read       (read_a),
        .clear_req  (clear_req),
        .busy       (busy_a),
        .clear_done (clear_done_a),
        .wr_reject  (wr_reject_a)
    );

    reg_file_param #(
        .DATA_W   (16),
        .ADDR_W   (5),
        .NUM_RD   (4),
        .ZERO_REG (0)
    ) dut_b (
        .clk        (clk),
        .clr        (clr),
        .regwrite   (regwrite),
        .writereg   (writereg),
        .data       (data[15:0]),
        .readreg    (readreg_b),
        .read       (read_b),
        .clear_req  (clear_req),
        .busy       (busy_b),
        .clear_done (clear_done_b),
        .wr_reject  (wr_reject_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] addr);
        readreg_a = {2{addr}};
        readreg_b = {4{addr}};
    endtask

    // Observes a sweep for a fixed 40 cycles starting right after its trigger edge.
    task automatic watch(output int cnt_a, output int pul_a, output int idx_a,
                         output int cnt_b, output int pul_b, output int idx_b);
        cnt_a = 0; pul_a = 0; idx_a = -1;
        cnt_b = 0; pul_b = 0; idx_b = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            if (clear_done_a) begin pul_a++; idx_a = i; end
            if (clear_done_b) begin pul_b++; idx_b = i; end
            cycle();
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int r = 0; r < 32; r++) begin
            set_rd(5'(r));
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (read_a[p*32 +: 32] !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL %s_a reg%0d port%0d: got %h expected 0", name, r, p, read_a[p*32 +: 32]);
                end
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (read_b[p*16 +: 16] !== 16'h0) begin
                    failures++;
                    $display("[TB] FAIL %s_b reg%0d port%0d: got %h expected 0", name, r, p, read_b[p*16 +: 16]);
                end
            end
        end
    endtask

    task automatic check_sweep(input string name, input int ca, input int pa, input int ia,
                               input int cb, input int pb, input int ib);
        checks++;
        if (ca !== 32 || pa !== 1 || ia !== 32) begin
            failures++;
            $display("[TB] FAIL %s_a: busy=%0d pulses=%0d done_at=%0d expected 32/1/32", name, ca, pa, ia);
        end
        checks++;
        if (cb !== 32 || pb !== 1 || ib !== 32) begin
            failures++;
            $display("[TB] FAIL %s_b: busy=%0d pulses=%0d done_at=%0d expected 32/1/32", name, cb, pb, ib);
        end
    endtask

    task automatic test_reset();
        int ca, pa, ia, cb, pb, ib;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        set_rd(5'd3);
        #1;
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b/%b expected 1/1", busy_a, busy_b);
        end
        checks++;
        if (clear_done_a !== 1'b0 || wr_reject_a !== 1'b0 || clear_done_b !== 1'b0 || wr_reject_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got done=%b rej=%b / done=%b rej=%b expected 0", clear_done_a, wr_reject_a, clear_done_b, wr_reject_b);
        end
        checks++;
        if (read_a !== 64'h0 || read_b !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_read: got %h / %h expected 0", read_a, read_b);
        end
        watch(ca, pa, ia, cb, pb, ib);
        check_sweep("reset_sweep", ca, pa, ia, cb, pb, ib);
        check_all_zero("reset_clear");
    endtask

    task automatic test_bypass();
        regwrite = 1'b1;
        writereg = 5'd7;
        data     = 32'hDEADBEEF;
        set_rd(5'd7);
        #1;
        checks++;
        if (read_a !== {2{32'hDEADBEEF}} || read_b !== {4{16'hBEEF}}) begin
            failures++;
            $display("[TB] FAIL bypass: got %h / %h expected DEADBEEF / BEEF", read_a, read_b);
        end
        cycle();
        regwrite = 1'b0;
        data     = 32'h0;
        #1;
        checks++;
        if (read_a !== {2{32'hDEADBEEF}} || read_b !== {4{16'hBEEF}}) begin
            failures++;
            $display("[TB] FAIL bypass_stored: got %h / %h expected DEADBEEF / BEEF", read_a, read_b);
        end
    endtask

    task automatic test_zero_reg();
        regwrite = 1'b1;
        writereg = 5'd0;
        data     = 32'h1234;
        set_rd(5'd0);
        #1;
        checks++;
        if (read_a !== 64'h0 || read_b !== {4{16'h1234}}) begin
            failures++;
            $display("[TB] FAIL zero_bypass: got %h / %h expected 0 / 1234", read_a, read_b);
        end
        cycle();
        regwrite = 1'b0;
        data     = 32'h0;
        #1;
        checks++;
        if (read_a !== 64'h0 || wr_reject_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_reg_a: got read=%h rej=%b expected 0/0", read_a, wr_reject_a);
        end
        checks++;
        if (read_b !== {4{16'h1234}} || wr_reject_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_reg_b: got read=%h rej=%b expected 1234/0", read_b, wr_reject_b);
        end
    endtask

    task automatic test_retain();
        regwrite = 1'b1;
        writereg = 5'd3;
        data     = 32'hA5;
        cycle();
        regwrite = 1'b0;
        data     = 32'hFFFF_FFFF;
        set_rd(5'd3);
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (read_a !== {2{32'hA5}} || read_b !== {4{16'hA5}}) begin
                failures++;
                $display("[TB] FAIL retain cyc%0d: got %h / %h expected A5", i, read_a, read_b);
            end
        end
    endtask

    task automatic test_sweep_reject();
        for (int r = 1; r < 32; r++) begin
            regwrite = 1'b1;
            writereg = 5'(r);
            data     = 32'(r);
            cycle();
        end
        regwrite = 1'b0;
        set_rd(5'd9);
        #1;
        checks++;
        if (read_a !== {2{32'd9}} || read_b !== {4{16'd9}}) begin
            failures++;
            $display("[TB] FAIL fill: got %h / %h expected 9", read_a, read_b);
        end
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || read_a !== 64'h0 || read_b !== 64'h0) begin
            failures++;
            $display("[TB] FAIL sweep_start: got busy=%b read=%h / %h expected 1 and 0", busy_a, read_a, read_b);
        end
        for (int i = 0; i < 10; i++) cycle();
        regwrite = 1'b1;
        writereg = 5'd5;
        data     = 32'h55;
        #1;
        checks++;
        if (wr_reject_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reject_early: got %b expected 0", wr_reject_a);
        end
        cycle();
        checks++;
        if (wr_reject_a !== 1'b1 || wr_reject_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reject: got %b/%b expected 1/1", wr_reject_a, wr_reject_b);
        end
        regwrite  = 1'b0;
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        checks++;
        if (wr_reject_a !== 1'b0 || wr_reject_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reject_clear: got %b/%b expected 0/0", wr_reject_a, wr_reject_b);
        end
        for (int i = 0; i < 19; i++) cycle();
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_last: got %b/%b expected 1/1", busy_a, busy_b);
        end
        regwrite = 1'b1;
        writereg = 5'd2;
        data     = 32'h99;
        cycle();
        regwrite = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || clear_done_a !== 1'b1 || wr_reject_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sweep_end_a: got busy=%b done=%b rej=%b expected 0/1/1", busy_a, clear_done_a, wr_reject_a);
        end
        checks++;
        if (busy_b !== 1'b0 || clear_done_b !== 1'b1 || wr_reject_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sweep_end_b: got busy=%b done=%b rej=%b expected 0/1/1", busy_b, clear_done_b, wr_reject_b);
        end
        check_all_zero("sweep_clear");
    endtask

    task automatic test_mid_sweep_clr();
        int ca, pa, ia, cb, pb, ib;
        for (int r = 1; r < 32; r++) begin
            regwrite = 1'b1;
            writereg = 5'(r);
            data     = 32'(r * 3 + 1);
            cycle();
        end
        regwrite = 1'b0;
        set_rd(5'd20);
        #1;
        checks++;
        if (read_a !== {2{32'd61}} || read_b !== {4{16'd61}}) begin
            failures++;
            $display("[TB] FAIL ports_agree: got %h / %h expected 61 on all ports", read_a, read_b);
        end
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        watch(ca, pa, ia, cb, pb, ib);
        check_sweep("mid_clr", ca, pa, ia, cb, pb, ib);
        check_all_zero("mid_clr_clear");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        clr       = 1'b0;
        regwrite  = 1'b0;
        writereg  = 5'd0;
        data      = 32'h0;
        clear_req = 1'b0;
        readreg_a = '0;
        readreg_b = '0;
        cycle();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_retain();
        test_sweep_reject();
        test_mid_sweep_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
